// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register: a main entry drives the outputs and a
// skid entry absorbs one extra beat, so in_ready is registered and never combinational.
module pipe_stage_reg #(
    parameter int DATA_W   = 16,
    parameter int CTRL_W   = 8,
    parameter int CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic                accept_s;
    logic                pop_s;
    logic                load_main_in_s;
    logic                load_main_skid_s;
    logic                load_skid_in_s;
    logic                clr_main_ctrl_s;

    // Next-state decode and storage load strobes.
    always_comb begin
        accept_s         = in_valid & in_ready_r & ~flush;
        pop_s            = out_valid_r & out_ready & ~stall;
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_in_s   = 1'b0;
        clr_main_ctrl_s  = 1'b0;
        if (flush) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_next_s   = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_next_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !pop_s) begin
                        state_next_s   = TWO;
                        load_skid_in_s = 1'b1;
                    end else if (pop_s && !accept_s) begin
                        state_next_s    = EMPTY;
                        clr_main_ctrl_s = 1'b1;
                    end else if (accept_s && pop_s) begin
                        state_next_s   = ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_next_s = ONE;
                    end
                end
                TWO: begin
                    if (pop_s) begin
                        state_next_s     = ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_next_s = TWO;
                    end
                end
                default: begin
                    state_next_s = EMPTY;
                end
            endcase
        end
    end

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != TWO);
            out_valid_r <= (state_next_s != EMPTY);
        end
    end

    // Payload and control storage; flush kills ctrl always, payload only with CLR_DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else if (flush) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            if (CLR_DATA != 0) begin
                main_data_r <= {DATA_W{1'b0}};
                skid_data_r <= {DATA_W{1'b0}};
            end
        end else begin
            if (load_main_in_s) begin
                main_data_r <= in_data;
                main_ctrl_r <= in_ctrl;
            end else if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
                main_ctrl_r <= skid_ctrl_r;
            end else if (clr_main_ctrl_s) begin
                main_ctrl_r <= {CTRL_W{1'b0}};
            end
            if (load_skid_in_s) begin
                skid_data_r <= in_data;
                skid_ctrl_r <= in_ctrl;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign out_ctrl  = out_valid_r ? main_ctrl_r : {CTRL_W{1'b0}};
    assign occupancy = state_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a scoreboard queue tracks accepted beats, and a
// wide CLR_DATA=1 instance runs on the same stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [63:0] out_data_w;
    logic [15:0] out_ctrl_w;
    logic [1:0]  occupancy_w;

    logic [23:0] sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .CLR_DATA(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .CLR_DATA(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data({48'd0, in_data}), .in_ctrl({8'd0, in_ctrl}), .stall(stall), .flush(flush),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_ctrl(out_ctrl_w), .occupancy(occupancy_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake on the current inputs, advance, then check outputs.
    task automatic tick();
        bit acc;
        bit pp;
        acc = in_valid && (sb_q.size() < 2) && !flush;
        pp  = (sb_q.size() != 0) && out_ready && !stall;
        if (pp) void'(sb_q.pop_front());
        if (flush) sb_q.delete();
        else if (acc) sb_q.push_back({in_ctrl, in_data});
        @(posedge clk);
        #1;
        chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
        chk("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
        chk("wide_occupancy", 64'(occupancy_w), 64'(sb_q.size()));
        if (sb_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(sb_q[0][15:0]));
            chk("out_ctrl", 64'(out_ctrl), 64'(sb_q[0][23:16]));
            chk("wide_out_data", out_data_w, {48'd0, sb_q[0][15:0]});
        end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
            chk("wide_bubble_ctrl", 64'(out_ctrl_w), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_ctrl = 8'h00;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // Streaming at full rate: occupancy stays at one.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_ctrl = 8'(i);
            tick();
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure fills both entries, third offer is refused.
        stall = 1'b1; in_valid = 1'b1;
        in_data = 16'hAAAA; in_ctrl = 8'h0A; tick();
        in_data = 16'h5555; in_ctrl = 8'h05; tick();
        chk("bp_occ", 64'(occupancy), 64'd2);
        in_data = 16'h1234; in_ctrl = 8'h12; tick();
        chk("bp_hold", 64'(out_data), 64'hAAAA);
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk("bp_second", 64'(out_data), 64'h5555);
        tick();
        chk("bp_ready", 64'(in_ready), 64'd1);

        // Flush while full with an offered beat.
        stall = 1'b1; in_valid = 1'b1;
        in_data = 16'h0BAD; in_ctrl = 8'h33; tick();
        in_data = 16'h0F00; in_ctrl = 8'h44; tick();
        flush = 1'b1; in_data = 16'hDEAD; in_ctrl = 8'hFF; tick();
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_data_kept", 64'(out_data), 64'h0BAD);
        chk("flush_wide_data_zero", out_data_w, 64'd0);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        tick();
        tick();

        // Accept and pop in the same cycle while holding one beat.
        in_valid = 1'b1; in_data = 16'h1111; in_ctrl = 8'h11; tick();
        in_data = 16'h2222; in_ctrl = 8'h22; tick();
        chk("swap_occ", 64'(occupancy), 64'd1);
        chk("swap_data", 64'(out_data), 64'h2222);
        in_valid = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_ctrl   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset in the middle of a cycle while full.
        stall = 1'b1; in_valid = 1'b1;
        in_data = 16'h7777; in_ctrl = 8'h77; tick();
        in_data = 16'h8888; in_ctrl = 8'h88; tick();
        chk("pre_reset_occ", 64'(occupancy), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("async_occ", 64'(occupancy), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        chk("post_reset_occ", 64'(occupancy), 64'd0);
        in_valid = 1'b1; in_data = 16'h0042; in_ctrl = 8'h01; tick();
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 16, payload width in bits (operands, instruction, PC); legal range 1..256.
REQ-002 Parameter CTRL_W, 8, control-field width in bits (write enables, halt, jump); legal range 1..64.
REQ-003 Parameter CLR_DATA, 0, when 1 the flush and reset paths also zero payload storage.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream presents a beat.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control field.
REQ-010 stall  input  1  downstream hold: while 1, no beat leaves the stage.
REQ-011 flush  input  1  synchronous kill of all held beats and any beat offered this cycle.
REQ-012 out_valid  output  1  stage holds a valid beat.
REQ-013 out_ready  input  1  downstream accepts the beat.
REQ-014 out_data  output  DATA_W  payload of the head beat.
REQ-015 out_ctrl  output  CTRL_W  control field of the head beat, forced to zero when out_valid=0.
REQ-016 occupancy  output  2  number of held beats, 0..2.

Function
REQ-017 The stage SHALL hold two entries, main (drives outputs) and skid; state EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
REQ-018 accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~stall.
REQ-019 in_ready SHALL be 1 exactly when state is not TWO, and SHALL be a registered signal with no combinational path from out_ready, stall or flush.
REQ-020 EMPTY: accept -> ONE with main <= in; otherwise stay.
REQ-021 ONE: accept & ~pop -> TWO with skid <= in; pop & ~accept -> EMPTY; accept & pop -> ONE with main <= in; neither -> stay.
REQ-022 TWO: pop -> ONE with main <= skid; otherwise stay with all storage unchanged.
REQ-023 flush=1 SHALL move state to EMPTY on that edge regardless of in_valid, pop, or stall, zero both ctrl entries, and discard the offered beat.
REQ-024 When CLR_DATA=1, flush SHALL also zero both payload entries; when 0, payload storage SHALL keep its prior value.
REQ-025 Latency SHALL be one cycle: a beat accepted at edge N appears on out_* after edge N when the stage was EMPTY, or in ONE with pop at edge N.
REQ-026 Beats SHALL leave in acceptance order with no loss or duplication; throughput SHALL be one beat per cycle while out_ready=1 and stall=0.
REQ-027 out_ctrl SHALL be zero whenever out_valid=0 (bubble semantics), independent of stored ctrl bits.
REQ-028 out_data with out_valid=0 SHALL hold the last main payload (zero after reset).
REQ-029 occupancy SHALL equal the registered state encoding, 0/1/2; value 3 SHALL never occur.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force state EMPTY, occupancy 0, out_valid 0, out_ctrl 0, out_data 0, in_ready 0.
REQ-031 in_ready SHALL rise on the first rising edge after rst_n deasserts; any beat in flight when reset asserts SHALL be lost.

Verification
REQ-032 Stream: in_valid=1 with data 0x0001..0x0008, out_ready=1, stall=0 -> outputs 0x0001..0x0008 on consecutive cycles, occupancy steady at 1.
REQ-033 Backpressure: stall=1 after two beats (0xAAAA, 0x5555) -> occupancy 2, in_ready 0, out_data 0xAAAA held; stall=0 -> 0xAAAA then 0x5555, in_ready returns to 1.
REQ-034 Flush in TWO with in_valid=1, in_ctrl=0xFF -> next cycle occupancy 0, out_valid 0, out_ctrl 0x00; that beat never appears.
REQ-035 Simultaneous accept and pop in ONE: main 0x1111 popped, 0x2222 loaded -> occupancy stays 1, out_data 0x2222.
REQ-036 Asynchronous reset mid-clock with occupancy 2 -> out_valid, out_ctrl, occupancy 0 before the next edge; in_ready 1 one edge after release.
REQ-037 Parameter sweep: DATA_W=1/CTRL_W=1, DATA_W=64/CTRL_W=16 with CLR_DATA=1 -> REQ-032..036 pass, and out_data=0 after flush.
